// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states,
// parity-mode constants and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-OVERSAMPLE baud-tick counter; o_bit_end strobes on the tick that
// completes a bit period. i_clear restarts the period.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_bit_end
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] r_cnt = '0;

    // Wraps at OVERSAMPLE-1 explicitly so non-power-of-two ratios work.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_bit_end = i_tick && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter. Optional parity stage is built only when
// the macro UART_TX_PARITY_EN is defined; otherwise frames never carry parity.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done_tick,
    output uart_state_t       o_dbg_state
);

    // Handshake: a payload moves on a cycle where data_valid && data_ready;
    // data_ready is high only in IDLE, so upstream holds its word while busy.

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_t       r_state   = ST_IDLE;
    uart_state_t       w_next;
    logic [DATA_W-1:0] r_shift   = '0;
    logic [3:0]        r_bit_cnt = '0;
    logic              w_accept;
    logic              w_tick;
    logic              w_bit_end;
    logic              w_done;
    logic              w_par_on;

`ifdef UART_TX_PARITY_EN
    logic r_par_en  = 1'b0;
    logic r_par_bit = 1'b0;
    assign w_par_on = r_par_en;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = cfg_parity_en ^ cfg_parity_odd;
    assign w_par_on     = 1'b0;
`endif

    assign w_accept = data_valid && (r_state == ST_IDLE);
    assign w_tick   = baud_tick && (r_state != ST_IDLE);

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_tick    (w_tick),
        .o_bit_end (w_bit_end)
    );

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_START;
            ST_START: if (w_bit_end) w_next = ST_DATA;
            ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == LAST_DATA)) begin
                    w_next = w_par_on ? ST_PARITY : ST_STOP;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_bit_end) w_next = ST_STOP;
`endif
            ST_STOP: begin
                if (w_bit_end && (r_bit_cnt == LAST_STOP)) begin
                    w_next = ST_IDLE;
                    w_done = !rst;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_shift   <= data_in;
                r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                r_par_en  <= cfg_parity_en;
                r_par_bit <= (^data_in) ^ (cfg_parity_odd == PAR_ODD);
`endif
            end else if (w_bit_end && (r_state == ST_DATA || r_state == ST_STOP)) begin
                // Bit counter is shared by DATA and STOP; it restarts on leaving either.
                r_bit_cnt <= (w_next != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
                if (r_state == ST_DATA) r_shift <= r_shift >> 1;
            end
        end
    end

    always_comb begin
        serial_out = STOP_BIT;
        case (r_state)
            ST_START:  serial_out = START_BIT;
            ST_DATA:   serial_out = r_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_out = r_par_bit;
`endif
            default:   serial_out = STOP_BIT;
        endcase
    end

    assign data_ready   = (r_state == ST_IDLE);
    assign busy         = !data_ready;
    assign tx_done_tick = w_done;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances (default, 7N2, OVERSAMPLE=10),
// table-driven frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_cfg;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] dv = 3'b000;
    logic       pe = 1'b0;
    logic       po = 1'b0;
    logic [2:0] ser, rdy, bsy, don;
    uart_state_t st0, st1, st2;

    int total = 0;
    int bad   = 0;
    int div   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid(dv[0]), .data_ready(rdy[0]), .cfg_parity_en(pe),
        .cfg_parity_odd(po), .serial_out(ser[0]), .busy(bsy[0]),
        .tx_done_tick(don[0]), .o_dbg_state(st0)
    );

    uart_tx_cfg #(.DATA_W(7), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in[6:0]),
        .data_valid(dv[1]), .data_ready(rdy[1]), .cfg_parity_en(pe),
        .cfg_parity_odd(po), .serial_out(ser[1]), .busy(bsy[1]),
        .tx_done_tick(don[1]), .o_dbg_state(st1)
    );

    uart_tx_cfg #(.OVERSAMPLE(10)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid(dv[2]), .data_ready(rdy[2]), .cfg_parity_en(pe),
        .cfg_parity_odd(po), .serial_out(ser[2]), .busy(bsy[2]),
        .tx_done_tick(don[2]), .o_dbg_state(st2)
    );

    typedef struct {
        logic [7:0]  data;
        logic        p_en;
        logic        p_odd;
        logic [11:0] exp;
        int          len;
        string       name;
    } vec_t;

    vec_t vecs[8];

    // Frame bit i (transmit order) sits at position i: start, data LSB first, [parity], stop.
    function automatic logic [11:0] fr(logic [7:0] d, logic pb, logic has_par);
        return has_par ? {2'b01, pb, d, 1'b0} : {3'b001, d, 1'b0};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: baud_tick every 4th cycle, outputs sampled 1 ns after the falling edge.
    task automatic step();
        @(negedge clk);
        div = (div + 1) % 4;
        baud_tick = (div == 0);
        #1;
    endtask

    task automatic send(int sel, logic [7:0] d, logic p_e, logic p_o);
        for (int i = 0; i < 200; i++) begin
            step();
            if (rdy[sel]) break;
        end
        chk("send_ready", 32'(rdy[sel]), 32'd1);
        data_in = d;
        pe = p_e;
        po = p_o;
        dv[sel] = 1'b1;
    endtask

    task automatic monitor(int sel, logic [11:0] exp, int len, int os,
                           logic hold, logic [7:0] nxt, string name);
        int t = 0;
        int err = 0;
        int ndone = 0;
        int donebad = 0;
        int cyc = 0;
        while (t < len * os && cyc < len * os * 4 + 40) begin
            step();
            if (cyc == 0) begin
                if (hold) begin
                    data_in = nxt;
                end else begin
                    dv[sel] = 1'b0;
                    data_in = ~data_in;
                    pe = ~pe;
                    po = ~po;
                end
            end
            if (ser[sel] !== exp[t / os]) err++;
            if (rdy[sel] !== 1'b0 || bsy[sel] !== 1'b1) err++;
            if (don[sel]) begin
                ndone++;
                if (!(baud_tick && (t + 1 == len * os))) donebad++;
            end
            if (baud_tick) t++;
            cyc++;
        end
        chk({name, "_line"}, 32'(err), 32'd0);
        chk({name, "_ticks"}, 32'(t), 32'(len * os));
        chk({name, "_done_cnt"}, 32'(ndone), 32'd1);
        chk({name, "_done_when"}, 32'(donebad), 32'd0);
        step();
        chk({name, "_ready_after"}, 32'(rdy[sel]), 32'd1);
        chk({name, "_line_after"}, 32'(ser[sel]), 32'd1);
        chk({name, "_done_after"}, 32'(don[sel]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err;
        int t;
        int ndone;

        vecs[0] = '{8'h55, 1'b0, 1'b0, fr(8'h55, 1'b0, 1'b0), 10, "v55"};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, fr(8'hA3, 1'b0, 1'b0), 10, "vA3"};
        vecs[2] = '{8'h00, 1'b0, 1'b1, fr(8'h00, 1'b0, 1'b0), 10, "v00"};
        vecs[3] = '{8'h07, 1'b1, 1'b0, fr(8'h07, 1'b1, PAR_BUILT), 10 + int'(PAR_BUILT), "v07_even"};
        vecs[4] = '{8'h07, 1'b1, 1'b1, fr(8'h07, 1'b0, PAR_BUILT), 10 + int'(PAR_BUILT), "v07_odd"};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, fr(8'hFF, 1'b1, PAR_BUILT), 10 + int'(PAR_BUILT), "vFF_odd"};
        vecs[6] = '{8'h80, 1'b1, 1'b0, fr(8'h80, 1'b1, PAR_BUILT), 10 + int'(PAR_BUILT), "v80_even"};
        vecs[7] = '{8'h55, 1'b1, 1'b0, fr(8'h55, 1'b0, PAR_BUILT), 10 + int'(PAR_BUILT), "v55_even"};

        // Reset state of every instance
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step();
        for (int s = 0; s < 3; s++) begin
            chk("rst_serial", 32'(ser[s]), 32'd1);
            chk("rst_ready", 32'(rdy[s]), 32'd1);
            chk("rst_busy", 32'(bsy[s]), 32'd0);
            chk("rst_done", 32'(don[s]), 32'd0);
        end
        chk("rst_state0", 32'(st0), 32'(ST_IDLE));
        chk("rst_state1", 32'(st1), 32'(ST_IDLE));
        chk("rst_state2", 32'(st2), 32'(ST_IDLE));
        rst = 1'b0;

        // Ticks while idle leave the line high and nothing starts
        err = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ser !== 3'b111 || rdy !== 3'b111 || don !== 3'b000) err++;
        end
        chk("idle_ticks", 32'(err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            send(0, vecs[i].data, vecs[i].p_en, vecs[i].p_odd);
            monitor(0, vecs[i].exp, vecs[i].len, 16, 1'b0, 8'h00, vecs[i].name);
        end

        // 7 data bits, two stop bits
        send(1, 8'h7F, 1'b0, 1'b0);
        monitor(1, {2'b00, 2'b11, 7'h7F, 1'b0}, 10, 16, 1'b0, 8'h00, "d7s2_7F");
        send(1, 8'h12, 1'b0, 1'b0);
        monitor(1, {2'b00, 2'b11, 7'h12, 1'b0}, 10, 16, 1'b0, 8'h00, "d7s2_12");

        // OVERSAMPLE=10: every bit exactly 10 ticks
        send(2, 8'h55, 1'b0, 1'b0);
        monitor(2, fr(8'h55, 1'b0, 1'b0), 10, 10, 1'b0, 8'h00, "os10_55");
        send(2, 8'hC4, 1'b0, 1'b0);
        monitor(2, fr(8'hC4, 1'b0, 1'b0), 10, 10, 1'b0, 8'h00, "os10_C4");

        // Back-to-back: valid held, 0x3C waits until the first frame ends
        send(0, 8'hA5, 1'b0, 1'b0);
        monitor(0, fr(8'hA5, 1'b0, 1'b0), 10, 16, 1'b1, 8'h3C, "b2b_A5");
        monitor(0, fr(8'h3C, 1'b0, 1'b0), 10, 16, 1'b0, 8'h00, "b2b_3C");

        // Reset on the 70th tick of a frame (line low there: data bit 3 of 0x55)
        send(0, 8'h55, 1'b0, 1'b0);
        t = 0;
        ndone = 0;
        for (int c = 0; c < 400 && t < 70; c++) begin
            step();
            if (c == 0) dv[0] = 1'b0;
            if (don[0]) ndone++;
            if (baud_tick) begin
                t++;
                if (t == 70) begin
                    chk("abort_line_low", 32'(ser[0]), 32'd0);
                    rst = 1'b1;
                end
            end
        end
        chk("abort_reached", 32'(t), 32'd70);
        step();
        rst = 1'b0;
        chk("abort_serial", 32'(ser[0]), 32'd1);
        chk("abort_ready", 32'(rdy[0]), 32'd1);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        if (don[0]) ndone++;
        for (int i = 0; i < 100; i++) begin
            step();
            if (don[0]) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        send(0, 8'hA3, 1'b0, 1'b0);
        monitor(0, fr(8'hA3, 1'b0, 1'b0), 10, 16, 1'b0, 8'h00, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning baud_tick pulses per bit period (legal 4..64, any integer).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge), rst input 1.
REQ-005 SHALL have port baud_tick, input, 1 bit: oversample strobe, single-cycle pulse.
REQ-006 SHALL have port data_in, input, DATA_W bits: frame payload, sent LSB first.
REQ-007 SHALL have port data_valid, input, 1 bit: payload offered.
REQ-008 SHALL have port data_ready, output, 1 bit: block can accept a payload.
REQ-009 SHALL have port cfg_parity_en, input, 1 bit: parity bit is appended when high.
REQ-010 SHALL have port cfg_parity_odd, input, 1 bit: 1 = odd parity, 0 = even parity.
REQ-011 SHALL have port serial_out, output, 1 bit: line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: frame in progress.
REQ-013 SHALL have port tx_done_tick, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; data_ready = (state==IDLE); busy = !data_ready.
REQ-015 SHALL accept a payload only on a cycle with data_valid && data_ready; data_in and cfg_* SHALL be captured then, and later changes SHALL be ignored until the next accept.
REQ-016 SHALL drive serial_out low (start bit) from the cycle after accept, clear the tick counter at accept, and enter START.
REQ-017 Each bit SHALL last exactly OVERSAMPLE baud_tick pulses; the state/bit advances on the cycle the OVERSAMPLE-th tick is seen; cycles without baud_tick SHALL hold all state.
REQ-018 Transitions: START->DATA; DATA (after DATA_W bits)->PARITY if captured parity_en, else STOP; PARITY->STOP; STOP (after STOP_BITS bits)->IDLE.
REQ-019 The parity bit SHALL be the XOR of the DATA_W captured bits, inverted when odd parity is captured.
REQ-020 serial_out SHALL be high in STOP and IDLE.
REQ-021 tx_done_tick SHALL pulse for exactly one cycle on the cycle STOP->IDLE occurs; data_ready SHALL be high the following cycle, so back-to-back frames have no extra idle bit.
REQ-022 baud_tick SHALL be ignored in IDLE; data_valid while busy SHALL be held off (no accept, no data loss on the upstream side).
REQ-023 The bit-period counter SHALL be ceil(log2(OVERSAMPLE)) wide and wrap to 0 at OVERSAMPLE-1, not at a power of two.

Reset
REQ-024 On rst, from the next cycle: state IDLE, serial_out=1, data_ready=1, busy=0, tx_done_tick=0, counters 0.
REQ-025 rst mid-frame SHALL abort the frame immediately with no tx_done_tick; the line returns high the next cycle.
REQ-026 Registers SHALL also carry power-up initial values equal to the reset values.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, the PARITY state and logic are built per REQ-018/019.
REQ-028 When UART_TX_PARITY_EN is undefined, the PARITY state and logic SHALL NOT be built; cfg_parity_en and cfg_parity_odd SHALL remain as ports but be ignored; frames are always no-parity.

Structure
REQ-029 Package uart_pkg SHALL hold the state encoding constants, parity-mode constants (PAR_EVEN=0, PAR_ODD=1) and the line levels START_BIT=0, STOP_BIT=1.
REQ-030 Sub-module uart_bit_timer (OVERSAMPLE-modulo tick counter, clear input, end-of-bit strobe output) SHALL be instantiated once; all other logic is inline.

Verification (OVERSAMPLE=16, baud_tick every 4 clk unless noted)
REQ-031 Accept 0x55, parity off, STOP_BITS=1 -> line 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each held 16 ticks; tx_done_tick after 160 ticks.
REQ-032 Macro on, 0x07 with even parity -> parity bit 1; with odd parity -> parity bit 0; frame is 176 ticks.
REQ-033 STOP_BITS=2, DATA_W=7, 0x7F -> 10 bit periods (160 ticks) with the last two high; one done pulse.
REQ-034 data_valid held high with 0xA5 then 0x3C -> second start bit begins on the cycle after the first frame's tx_done_tick; 0x3C is not accepted while busy.
REQ-035 rst asserted at tick 70 of a frame -> serial_out=1 and data_ready=1 the next cycle; no tx_done_tick; a new frame then transmits correctly.
REQ-036 OVERSAMPLE=10 build -> every bit period is exactly 10 ticks (counter wraps at 9).
